// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control FSM: states, opcodes and mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        EXEC_LUI = 4'd4,
        WB_ALU   = 4'd5,
        MEM_ADDR = 4'd6,
        MEM_RD   = 4'd7,
        MEM_WB   = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11,
        ILLEGAL  = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] WB_SEL_ALUOUT = 2'b00;
    localparam logic [1:0] WB_SEL_MDR    = 2'b01;
    localparam logic [1:0] WB_SEL_PC     = 2'b10;

    localparam logic [1:0] A_SEL_PC    = 2'b00;
    localparam logic [1:0] A_SEL_A     = 2'b01;
    localparam logic [1:0] A_SEL_OLDPC = 2'b10;
    localparam logic [1:0] A_SEL_ZERO  = 2'b11;

    localparam logic [1:0] B_SEL_B    = 2'b00;
    localparam logic [1:0] B_SEL_IMM  = 2'b01;
    localparam logic [1:0] B_SEL_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_FUNCT = 2'b01;
    localparam logic [1:0] ALU_CMP   = 2'b10;

    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decoder from FSM state plus handshake/branch inputs to datapath control signals.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic       i_rst_n,
    input  state_t     i_state,
    input  logic       i_mem_ready,
    input  logic       i_br_taken,
    input  logic       i_abort,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_addr_sel,
    output logic       o_pc_load,
    output logic       o_oldpc_load,
    output logic       o_ir_load,
    output logic       o_ab_load,
    output logic       o_aluout_load,
    output logic       o_mdr_load,
    output logic       o_rf_we,
    output logic [1:0] o_wb_sel,
    output logic [1:0] o_alu_a_sel,
    output logic [1:0] o_alu_b_sel,
    output logic [1:0] o_alu_op,
    output logic       o_pc_src,
    output logic       o_illegal
);

    always_comb begin
        o_mem_req     = 1'b0;
        o_mem_we      = 1'b0;
        o_addr_sel    = 1'b0;
        o_pc_load     = 1'b0;
        o_oldpc_load  = 1'b0;
        o_ir_load     = 1'b0;
        o_ab_load     = 1'b0;
        o_aluout_load = 1'b0;
        o_mdr_load    = 1'b0;
        o_rf_we       = 1'b0;
        o_wb_sel      = WB_SEL_ALUOUT;
        o_alu_a_sel   = A_SEL_PC;
        o_alu_b_sel   = B_SEL_B;
        o_alu_op      = ALU_ADD;
        o_pc_src      = 1'b0;
        o_illegal     = 1'b0;
        // Reset overrides the whole decode so nothing leaks out mid-access.
        if (i_rst_n) begin
            case (i_state)
                FETCH: begin
                    o_mem_req    = 1'b1;
                    o_addr_sel   = 1'b1;
                    o_alu_b_sel  = B_SEL_FOUR;
                    o_ir_load    = i_mem_ready;
                    o_oldpc_load = i_mem_ready;
                    o_pc_load    = i_mem_ready;
                end
                DECODE: begin
                    o_ab_load     = 1'b1;
                    o_aluout_load = 1'b1;
                    o_alu_a_sel   = A_SEL_OLDPC;
                    o_alu_b_sel   = B_SEL_IMM;
                end
                EXEC_R: begin
                    o_alu_a_sel   = A_SEL_A;
                    o_alu_op      = ALU_FUNCT;
                    o_aluout_load = 1'b1;
                end
                EXEC_I: begin
                    o_alu_a_sel   = A_SEL_A;
                    o_alu_b_sel   = B_SEL_IMM;
                    o_alu_op      = ALU_FUNCT;
                    o_aluout_load = 1'b1;
                end
                EXEC_LUI: begin
                    o_alu_a_sel   = A_SEL_ZERO;
                    o_alu_b_sel   = B_SEL_IMM;
                    o_aluout_load = 1'b1;
                end
                WB_ALU: o_rf_we = 1'b1;
                MEM_ADDR: begin
                    o_alu_a_sel   = A_SEL_A;
                    o_alu_b_sel   = B_SEL_IMM;
                    o_aluout_load = 1'b1;
                end
                MEM_RD: begin
                    o_mem_req  = 1'b1;
                    o_mdr_load = i_mem_ready;
                end
                MEM_WB: begin
                    o_rf_we  = 1'b1;
                    o_wb_sel = WB_SEL_MDR;
                end
                MEM_WR: begin
                    o_mem_req = 1'b1;
                    o_mem_we  = 1'b1;
                end
                BRANCH: begin
                    o_alu_a_sel = A_SEL_A;
                    o_alu_op    = ALU_CMP;
                    o_pc_load   = i_br_taken;
                    o_pc_src    = 1'b1;
                end
                JAL: begin
                    o_rf_we   = 1'b1;
                    o_wb_sel  = WB_SEL_PC;
                    o_pc_load = 1'b1;
                    o_pc_src  = 1'b1;
                end
                ILLEGAL: o_illegal = 1'b1;
                default: ;
            endcase
            if (i_abort) begin
                o_mem_req = 1'b0;
                o_mem_we  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: state register, next-state logic, memory handshake.
// Define MC_CTRL_TIMEOUT_EN to abort memory waits into ILLEGAL after 2^TO_W-1 wait cycles.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int TO_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       pc_load,
    output logic       oldpc_load,
    output logic       ir_load,
    output logic       ab_load,
    output logic       aluout_load,
    output logic       mdr_load,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic [1:0] alu_op,
    output logic       pc_src,
    output logic       illegal,
    output logic [3:0] state
);

    state_t r_state;
    state_t w_next;
    logic   w_timeout;

    if (TO_W < 1) begin : g_to_w_check
        $error("TO_W must be at least 1");
    end

`ifdef MC_CTRL_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;

    // Counter restarts whenever the state changes, so each wait state gets a fresh budget.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (w_next != r_state) begin
            r_to_cnt <= '0;
        end else if (is_wait_state(r_state) && !mem_ready) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = is_wait_state(r_state) && !mem_ready && (r_to_cnt == {TO_W{1'b1}});
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    if (mem_ready) w_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:               w_next = EXEC_R;
                    OP_I:               w_next = EXEC_I;
                    OP_LUI:             w_next = EXEC_LUI;
                    OP_LOAD, OP_STORE:  w_next = MEM_ADDR;
                    OP_BRANCH:          w_next = BRANCH;
                    OP_JAL:             w_next = JAL;
                    default:            w_next = ILLEGAL;
                endcase
            end
            EXEC_R, EXEC_I, EXEC_LUI: w_next = WB_ALU;
            WB_ALU:   w_next = FETCH;
            MEM_ADDR: w_next = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) w_next = MEM_WB;
            MEM_WB:   w_next = FETCH;
            MEM_WR:   if (mem_ready) w_next = FETCH;
            BRANCH:   w_next = FETCH;
            JAL:      w_next = FETCH;
            ILLEGAL:  w_next = ILLEGAL;
            default:  w_next = ILLEGAL;
        endcase
        if (w_timeout) w_next = ILLEGAL;
    end

    assign state = r_state;

    mc_ctrl_decode u_decode (
        .i_rst_n       (rst),
        .i_state       (r_state),
        .i_mem_ready   (mem_ready),
        .i_br_taken    (br_taken),
        .i_abort       (w_timeout),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_addr_sel    (addr_sel),
        .o_pc_load     (pc_load),
        .o_oldpc_load  (oldpc_load),
        .o_ir_load     (ir_load),
        .o_ab_load     (ab_load),
        .o_aluout_load (aluout_load),
        .o_mdr_load    (mdr_load),
        .o_rf_we       (rf_we),
        .o_wb_sel      (wb_sel),
        .o_alu_a_sel   (alu_a_sel),
        .o_alu_b_sel   (alu_b_sel),
        .o_alu_op      (alu_op),
        .o_pc_src      (pc_src),
        .o_illegal     (illegal)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; per-cycle expected outputs come from a state table.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       br_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, pc_load, oldpc_load, ir_load;
    logic       ab_load, aluout_load, mdr_load, rf_we, pc_src, illegal;
    logic [1:0] wb_sel, alu_a_sel, alu_b_sel, alu_op;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [23:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_ctrl #(.TO_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .br_taken    (br_taken),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .addr_sel    (addr_sel),
        .pc_load     (pc_load),
        .oldpc_load  (oldpc_load),
        .ir_load     (ir_load),
        .ab_load     (ab_load),
        .aluout_load (aluout_load),
        .mdr_load    (mdr_load),
        .rf_we       (rf_we),
        .wb_sel      (wb_sel),
        .alu_a_sel   (alu_a_sel),
        .alu_b_sel   (alu_b_sel),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .illegal     (illegal),
        .state       (state)
    );

    logic [23:0] obs;
    assign obs = {mem_req, mem_we, addr_sel, pc_load, oldpc_load, ir_load, ab_load,
                  aluout_load, mdr_load, rf_we, wb_sel, alu_a_sel, alu_b_sel, alu_op,
                  pc_src, illegal, state};

    // Expected outputs per state, written straight from the state table.
    function automatic logic [23:0] ref_out(input logic [3:0] st, input logic rdy,
                                            input logic bt, input bit abort);
        logic mreq, mwe, asel, pcl, opcl, irl, abl, alul, mdrl, rfwe, psrc, ill;
        logic [1:0] wb, as, bs, op;
        {mreq, mwe, asel, pcl, opcl, irl, abl, alul, mdrl, rfwe, psrc, ill} = '0;
        wb = 2'b00; as = 2'b00; bs = 2'b00; op = 2'b00;
        case (st)
            4'd0:  begin mreq = 1; asel = 1; bs = 2'b10; irl = rdy; opcl = rdy; pcl = rdy; end
            4'd1:  begin abl = 1; alul = 1; as = 2'b10; bs = 2'b01; end
            4'd2:  begin as = 2'b01; bs = 2'b00; op = 2'b01; alul = 1; end
            4'd3:  begin as = 2'b01; bs = 2'b01; op = 2'b01; alul = 1; end
            4'd4:  begin as = 2'b11; bs = 2'b01; alul = 1; end
            4'd5:  begin rfwe = 1; wb = 2'b00; end
            4'd6:  begin as = 2'b01; bs = 2'b01; alul = 1; end
            4'd7:  begin mreq = 1; mdrl = rdy; end
            4'd8:  begin rfwe = 1; wb = 2'b01; end
            4'd9:  begin mreq = 1; mwe = 1; end
            4'd10: begin as = 2'b01; bs = 2'b00; op = 2'b10; pcl = bt; psrc = 1; end
            4'd11: begin rfwe = 1; wb = 2'b10; pcl = 1; psrc = 1; end
            4'd12: ill = 1;
            default: ;
        endcase
        if (abort) begin mreq = 0; mwe = 0; end
        return {mreq, mwe, asel, pcl, opcl, irl, abl, alul, mdrl, rfwe, wb, as, bs, op,
                psrc, ill, st};
    endfunction

    task automatic chk();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=%h required=entry", obs);
        end else begin
            e = sb.pop_front();
            total++;
            assert (obs === e.v) else begin
                bad++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        sb.push_back('{tag: tag, v: 24'h0});
        chk();
    endtask

    // Drive one cycle's inputs right after the edge, compare on the falling edge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic rdy,
                       input logic bt, input bit abort = 1'b0);
        mem_ready = rdy;
        br_taken  = bt;
        sb.push_back('{tag: tag, v: ref_out(st, rdy, bt, abort)});
        @(negedge clk);
        chk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        chk_zero({tag, "_assert"});
        @(posedge clk);
        #1;
        chk_zero({tag, "_hold"});
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst       = 1'b0;
        opcode    = 7'h00;
        mem_ready = 1'b1;
        br_taken  = 1'b1;
        #1;
        chk_zero("reset_initial");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("reset_held");
        rst = 1'b1;

        opcode = 7'b0110011;
        cyc("r_fetch", 4'd0, 1, 0);
        cyc("r_decode", 4'd1, 1, 0);
        cyc("r_exec", 4'd2, 1, 0);
        cyc("r_wb", 4'd5, 1, 0);

        opcode = 7'b0010011;
        cyc("i_fetch", 4'd0, 1, 0);
        cyc("i_decode", 4'd1, 0, 0);
        cyc("i_exec", 4'd3, 1, 0);
        cyc("i_wb", 4'd5, 0, 0);

        opcode = 7'b0110111;
        cyc("lui_fetch", 4'd0, 1, 0);
        cyc("lui_decode", 4'd1, 1, 0);
        cyc("lui_exec", 4'd4, 1, 0);
        cyc("lui_wb", 4'd5, 1, 0);

        opcode = 7'b0000011;
        for (int i = 0; i < 3; i++) cyc("ld_fetch_wait", 4'd0, 0, 0);
        cyc("ld_fetch_rdy", 4'd0, 1, 0);
        cyc("ld_decode", 4'd1, 0, 0);
        cyc("ld_addr", 4'd6, 0, 0);
        for (int i = 0; i < 2; i++) cyc("ld_rd_wait", 4'd7, 0, 0);
        cyc("ld_rd_rdy", 4'd7, 1, 0);
        cyc("ld_wb", 4'd8, 1, 0);

        opcode = 7'b0100011;
        cyc("st_fetch", 4'd0, 1, 0);
        cyc("st_decode", 4'd1, 1, 0);
        cyc("st_addr", 4'd6, 1, 0);
        cyc("st_wr", 4'd9, 1, 0);

        opcode = 7'b1100011;
        cyc("bt_fetch", 4'd0, 1, 0);
        cyc("bt_decode", 4'd1, 1, 0);
        cyc("bt_taken", 4'd10, 1, 1);
        cyc("bn_fetch", 4'd0, 1, 0);
        cyc("bn_decode", 4'd1, 1, 0);
        cyc("bn_not_taken", 4'd10, 1, 0);

        opcode = 7'b1101111;
        cyc("jal_fetch", 4'd0, 1, 0);
        cyc("jal_decode", 4'd1, 1, 0);
        cyc("jal_exec", 4'd11, 0, 0);

        opcode = 7'b0000011;
        cyc("rl_fetch", 4'd0, 1, 0);
        cyc("rl_decode", 4'd1, 1, 0);
        cyc("rl_addr", 4'd6, 1, 0);
        cyc("rl_rd_wait", 4'd7, 0, 0);
        mem_ready = 1'b0;
        do_reset("rst_mid_rd");
        cyc("rst_release_fetch", 4'd0, 0, 0);
        opcode = 7'b0110011;
        cyc("rr_fetch", 4'd0, 1, 0);
        cyc("rr_decode", 4'd1, 1, 0);
        cyc("rr_exec", 4'd2, 1, 0);
        cyc("rr_wb", 4'd5, 1, 0);

`ifdef MC_CTRL_TIMEOUT_EN
        opcode = 7'b0100011;
        cyc("to_fetch", 4'd0, 1, 0);
        cyc("to_decode", 4'd1, 1, 0);
        cyc("to_addr", 4'd6, 1, 0);
        for (int i = 0; i < 15; i++) cyc("to_wr_wait", 4'd9, 0, 0);
        cyc("to_wr_abort", 4'd9, 0, 0, 1'b1);
        cyc("to_illegal", 4'd12, 1, 0);
        do_reset("to_rst");
        cyc("ok_fetch", 4'd0, 1, 0);
        cyc("ok_decode", 4'd1, 1, 0);
        cyc("ok_addr", 4'd6, 1, 0);
        for (int i = 0; i < 15; i++) cyc("ok_wr_wait", 4'd9, 0, 0);
        cyc("ok_wr_last_rdy", 4'd9, 1, 0);
        cyc("ok_back_fetch", 4'd0, 0, 0);
`else
        opcode = 7'b0100011;
        cyc("lw_fetch", 4'd0, 1, 0);
        cyc("lw_decode", 4'd1, 1, 0);
        cyc("lw_addr", 4'd6, 1, 0);
        for (int i = 0; i < 20; i++) cyc("lw_wr_wait", 4'd9, 0, 0);
        cyc("lw_wr_rdy", 4'd9, 1, 0);
        cyc("lw_back_fetch", 4'd0, 0, 0);
`endif

        opcode = 7'b1111111;
        cyc("ill_fetch", 4'd0, 1, 0);
        cyc("ill_decode", 4'd1, 1, 0);
        for (int i = 0; i < 20; i++) cyc("ill_hold", 4'd12, logic'(i % 2), logic'(i % 3 == 0));
        do_reset("ill_rst");
        opcode = 7'b1101111;
        cyc("post_ill_fetch", 4'd0, 1, 0);
        cyc("post_ill_decode", 4'd1, 1, 0);
        cyc("post_ill_jal", 4'd11, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
